// File: rtl/pp_skid_if.sv
// Operand-pair in / partial-product-array out handshake bundle for pp_skid_generator.
interface pp_skid_if #(
  parameter int unsigned W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           pp_valid;
  logic           pp_ready;
  logic [W*W-1:0] pp;
  logic           pp_last_zero;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, a, b, pp_ready,
    input  in_ready, pp_valid, pp, pp_last_zero
  );

  // Generator side.
  modport slave (
    input  in_valid, a, b, pp_ready,
    output in_ready, pp_valid, pp, pp_last_zero
  );
endinterface

// File: rtl/pp_skid_generator.sv
// Two-entry skid buffer feeding a partial-product array generator for a W x W unsigned multiply.
// in_ready depends only on registered state, so pp_ready never reaches upstream combinationally.
module pp_skid_generator #(
  parameter int unsigned W = 8
) (
  input  logic      clk,
  input  logic      rst,
  pp_skid_if.slave  bus
);
  localparam int unsigned PPW = W * W;

  logic           out_valid;
  logic           skid_valid;
  logic [W-1:0]   a_o;
  logic [W-1:0]   b_o;
  logic [W-1:0]   a_s;
  logic [W-1:0]   b_s;
  logic           accept;
  logic           out_free;
  logic [PPW-1:0] pp_c;

  assign accept   = bus.in_valid & ~skid_valid;
  assign out_free = ~out_valid | bus.pp_ready;

  // Output entry refills from skid first, then from upstream; a stalled output diverts to skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      a_o        <= '0;
      b_o        <= '0;
      a_s        <= '0;
      b_s        <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        a_o        <= a_s;
        b_o        <= b_s;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        a_o       <= bus.a;
        b_o       <= bus.b;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      a_s        <= bus.a;
      b_s        <= bus.b;
      skid_valid <= 1'b1;
    end
  end

  // Row i is a_o gated by b_o[i]; weighting by 2^i is left to the reduction tree.
  always_comb begin
    pp_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pp_c[i*W +: W] = a_o & {W{b_o[i]}};
    end
  end

  assign bus.pp           = pp_c;
  assign bus.pp_valid     = out_valid;
  assign bus.in_ready     = ~skid_valid;
  assign bus.pp_last_zero = ~(|a_o) | ~(|b_o);
endmodule

// File: doc/pp_skid_generator.md
PP_SKID_GENERATOR -- requirements
Module: pp_skid_generator

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream offers an operand pair.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-006 SHALL have port a, input, W, unsigned multiplicand.
REQ-007 SHALL have port b, input, W, unsigned multiplier.
REQ-008 SHALL have port pp_valid, output, 1, partial-product array valid, feeding the 4:2 compressor reduction tree.
REQ-009 SHALL have port pp_ready, input, 1, reduction tree consumes the array this cycle.
REQ-010 SHALL have port pp, output, W*W, flattened array: bit pp[i*W+j] = a[j] & b[i], where row i carries weight 2^i (unshifted on the bus).
REQ-011 SHALL have port pp_last_zero, output, 1, high when the presented operand pair has a == 0 or b == 0.

Function
REQ-012 SHALL hold two registered entries: an output entry (out_valid, a_o, b_o) and a skid entry (skid_valid, a_s, b_s).
REQ-013 SHALL drive in_ready = ~skid_valid, a pure register output with no combinational path from pp_ready.
REQ-014 SHALL accept a pair in a cycle when in_valid & in_ready; upstream holds a/b stable until accepted.
REQ-015 SHALL compute pp and pp_last_zero combinationally from a_o/b_o only; pp_valid = out_valid.
REQ-016 SHALL treat the output entry as free in a cycle when ~out_valid or (pp_valid & pp_ready).
REQ-017 SHALL, when the output entry is free and skid_valid, move the skid entry into the output entry and clear skid_valid.
REQ-018 SHALL, when the output entry is free, skid is empty and an accept occurs, load the accepted pair into the output entry (latency one cycle, accept to pp_valid).
REQ-019 SHALL, when the output entry is free, skid is empty and no accept occurs, clear out_valid.
REQ-020 SHALL, when the output entry is stalled (pp_valid & ~pp_ready) and an accept occurs, load the accepted pair into the skid entry and set skid_valid.
REQ-021 SHALL keep a_o, b_o, pp and pp_valid unchanged while pp_valid & ~pp_ready.
REQ-022 SHALL sustain one pair per cycle when pp_ready is held high, with no bubbles.
REQ-023 SHALL preserve order: pairs leave in acceptance order; none is dropped or duplicated.
REQ-024 SHALL never accept when both entries are full (in_ready low at that point).

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear out_valid and skid_valid, and zero a_o, b_o, a_s, b_s.
REQ-026 SHALL therefore present pp_valid = 0, in_ready = 1, pp = 0 and pp_last_zero = 1 in the cycle after reset.
REQ-027 SHALL discard any pair held in either entry when reset is asserted mid-operation, with rst taking priority over accept and consume.

Verification
REQ-028 SHALL test single transfer: a=8'hFF, b=8'h01 accepted with pp_ready=1 -> next cycle pp_valid=1, pp[7:0]=8'hFF, all other bits 0, pp_last_zero=0.
REQ-029 SHALL test the zero case: a=8'h00, b=8'hA5 -> pp all zero, pp_last_zero=1.
REQ-030 SHALL test back-pressure: pp_ready=0 and three pairs offered -> two accepted, in_ready=0 after the second, pp holds the first pair; on release, pairs 1, 2, 3 emerge in order.
REQ-031 SHALL test streaming: in_valid=pp_ready=1 for 16 cycles with a=i, b=i+1 -> 16 consecutive valid outputs, each row i equal to a & {W{b[i]}}.
REQ-032 SHALL test reset mid-stall: with both entries full, pulse rst for one cycle -> pp_valid=0 and in_ready=1 next cycle, and no stale pair emerges afterward.
REQ-033 SHALL test exhaustively for W=4: all 256 (a,b) pairs -> the reduction-tree reference sum of pp rows equals a*b.
